divider_datapath_sub: RTL and testbench
=======================================

// Module: divider_datapath_sub
// PURPOSE
//  Datapath end of the non-restoring division control interface. It executes the c0..c6 strobes
//  issued by the subtract control unit and returns the status inputs that unit consumes.
//  It returns s (sign of partial remainder A) and count7 (last iteration). It holds A, Q, M and
//  the iteration counter, and publishes remainder then quotient on a registered result bus.
// PARAMETERS
//  W      8   operand width; A is W+1 bits; iterations = W
//  CNT_W  3   counter width, $clog2(W)
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      synchronous, active-high reset
//  c0..c6    in   1 ea   control strobes from the control unit (meanings below)
//  dividend  in   W      sampled when c0=1
//  divisor   in   W      sampled when c0=1
//  s         out  1      A[W], combinational from the register
//  count7    out  1      (cnt == W-1), combinational from the register
//  outbus    out  W      registered result bus
//  out_valid out  1      registered; 1 the cycle after c5 or c6
//  out_sel   out  1      registered; 0 = remainder, 1 = quotient
//  div0      out  1      divide-by-zero flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst=1 at posedge): A, Q, M, cnt, outbus, out_valid, out_sel and div0 all clear to 0.
//    Reset wins over every strobe, including mid-division; the next c0 starts cleanly.
//  - All strobes act on the posedge where they are high. Register updates use pre-edge values.
//  - c0: A<=0, Q<=dividend, M<={1'b0,divisor}, cnt<=0. It has priority over c1..c4 on A, Q and cnt.
//  - c1: {A,Q}<={A,Q}<<1. Q[0] becomes 0. It has priority over c2 on A.
//  - c2: A<=A+M when c3=0; A<=A-M when c3=1. Arithmetic is modulo 2^(W+1).
//    c3 without c2 has no effect.
//  - c4: Q[0]<=~A[W] using the pre-edge A, and cnt<=cnt+1, wrapping at 2^CNT_W.
//    When c4 and c2 are both high (final restore), Q[0] takes the sign before the add,
//    then A<=A+M. Both happen on the same edge.
//  - c5: outbus<=A[W-1:0], out_sel<=0, out_valid<=1 (latency 1).
//  - c6: outbus<=Q, out_sel<=1, out_valid<=1 (latency 1). If c5 and c6 are both high, c6 wins.
//  - out_valid drops to 0 on any edge with neither c5 nor c6. outbus holds its last value.
//  - Expected strobe sequence per iteration: c1, then c2 (+c3 when s=0), then c4.
//    s is the value the control unit samples during the c1 cycle.
//  - count7 rises after the (W-1)th c4. The FSM samples it in the W-th c4 cycle.
//  - When unsigned dividend < 2^W and divisor != 0: remainder = dividend % divisor and
//    quotient = dividend / divisor, exact.
// CONFIGURATION
//  DIVDP_DIV0_DETECT_EN defined:
//    - On c0, div0<=(divisor==0). div0 is sticky until the next c0 or rst.
//    - While div0=1, c5 drives the latched dividend and c6 drives all-ones.
//  Not defined: div0 is tied to 0 and no extra logic is built.
// STRUCTURE
//  - Shared package alu_cn_pkg: W default, CNT_W, and OUT_SEL_REM/OUT_SEL_QUO localparams.
//    The control unit uses the same package.
//  - One sub-module, iter_counter: clear, increment, and last = (cnt==W-1).
//    Everything else stays inline.
// TESTING
//  1. Drive the control FSM sequence for 100/7
//     -> outbus=2 (out_sel=0), then 14 (out_sel=1); out_valid is high 1 cycle each.
//  2. 200/13 -> rem 5, quo 15. Checks the final restore path, where c2 and c4 are high together.
//  3. 255/1 -> rem 0, quo 255. 5/9 -> rem 5, quo 0.
//  4. Assert rst after the 4th c4 of 100/7 -> all registers 0, count7=0.
//     Then run 100/7 again -> 2 and 14.
//  5. Pulse c3 alone, and c1 together with c2 -> c3 has no effect; A is shifted only, not added.
//  6. DIVDP_DIV0_DETECT_EN defined, 37/0 -> div0=1, rem 37, quo 255.
//     Macro undefined -> div0 stays 0 throughout.

Source files
------------

// File: rtl/alu_cn_pkg.sv
// Shared constants for the non-restoring divider
// control unit and its datapath.
package alu_cn_pkg;

  localparam int DIV_W     = 8;
  localparam int DIV_CNT_W = $clog2(DIV_W);

  localparam logic OUT_SEL_REM = 1'b0;
  localparam logic OUT_SEL_QUO = 1'b1;

endpackage

// File: rtl/divider_datapath_sub_iter_counter.sv
// Iteration counter: clear on start, step per
// iteration, flag the last iteration.
module iter_counter
  import alu_cn_pkg::*;
#(
  parameter int W     = DIV_W,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  // Clear has priority over increment; wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign last = (cnt == CNT_W'(W - 1));

endmodule

// File: rtl/divider_datapath_sub.sv
// Non-restoring divider datapath driven by c0..c6.
// Optional feature macro: DIVDP_DIV0_DETECT_EN.
module divider_datapath_sub
  import alu_cn_pkg::*;
#(
  parameter int W     = DIV_W,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         c0,
  input  logic         c1,
  input  logic         c2,
  input  logic         c3,
  input  logic         c4,
  input  logic         c5,
  input  logic         c6,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         s,
  output logic         count7,
  output logic [W-1:0] outbus,
  output logic         out_valid,
  output logic         out_sel,
  output logic         div0
);

  logic [W:0]       a;
  logic [W-1:0]     q;
  logic [W:0]       m;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     rem_val;
  logic [W-1:0]     quo_val;

  assign s = a[W];

  // Partial remainder: load, shift, or add/sub.
  always_ff @(posedge clk) begin
    if (rst) begin
      a <= '0;
    end else if (c0) begin
      a <= '0;
    end else if (c1) begin
      a <= {a[W-1:0], q[W-1]};
    end else if (c2) begin
      a <= c3 ? (a - m) : (a + m);
    end
  end

  // Quotient: load, shift in 0, or set new bit
  // from the sign before this edge's add.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (c0) begin
      q <= dividend;
    end else if (c1) begin
      q <= {q[W-2:0], 1'b0};
    end else if (c4) begin
      q[0] <= ~a[W];
    end
  end

  // Divisor, zero-extended to the A width.
  always_ff @(posedge clk) begin
    if (rst) begin
      m <= '0;
    end else if (c0) begin
      m <= {1'b0, divisor};
    end
  end

  iter_counter #(
    .W     (W),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (c0),
    .inc  (c4),
    .cnt  (cnt),
    .last (count7)
  );

`ifdef DIVDP_DIV0_DETECT_EN
  logic [W-1:0] dvd;

  // Sticky zero-divisor flag plus saved dividend.
  always_ff @(posedge clk) begin
    if (rst) begin
      div0 <= 1'b0;
      dvd  <= '0;
    end else if (c0) begin
      div0 <= (divisor == '0);
      dvd  <= dividend;
    end
  end

  assign rem_val = div0 ? dvd : a[W-1:0];
  assign quo_val = div0 ? '1  : q;
`else
  assign div0    = 1'b0;
  assign rem_val = a[W-1:0];
  assign quo_val = q;
`endif

  // Registered result bus; quotient wins a tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      outbus    <= '0;
      out_sel   <= OUT_SEL_REM;
      out_valid <= 1'b0;
    end else begin
      out_valid <= c5 | c6;
      if (c6) begin
        outbus  <= quo_val;
        out_sel <= OUT_SEL_QUO;
      end else if (c5) begin
        outbus  <= rem_val;
        out_sel <= OUT_SEL_REM;
      end
    end
  end

endmodule

// File: tb/tb_divider_datapath_sub.sv
// Self-checking bench for divider_datapath_sub.
// Plays the control unit; checks against / and %.
module tb_divider_datapath_sub;
  import alu_cn_pkg::*;

  localparam int W = DIV_W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         c0 = 0, c1 = 0, c2 = 0, c3 = 0;
  logic         c4 = 0, c5 = 0, c6 = 0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor  = '0;
  logic         s, count7, out_valid, out_sel, div0;
  logic [W-1:0] outbus;

  int vectors     = 0;
  int miscompares = 0;

  divider_datapath_sub dut (
    .clk       (clk),
    .rst       (rst),
    .c0        (c0),
    .c1        (c1),
    .c2        (c2),
    .c3        (c3),
    .c4        (c4),
    .c5        (c5),
    .c6        (c6),
    .dividend  (dividend),
    .divisor   (divisor),
    .s         (s),
    .count7    (count7),
    .outbus    (outbus),
    .out_valid (out_valid),
    .out_sel   (out_sel),
    .div0      (div0)
  );

  always #5 clk = ~clk;

  task automatic idle_strobes;
    {c0, c1, c2, c3, c4, c5, c6} = '0;
  endtask

  task automatic start(input logic [W-1:0] a,
                       input logic [W-1:0] b);
    @(negedge clk);
    idle_strobes();
    c0 = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    c0 = 1'b0;
  endtask

  task automatic iter(input bit last, output bit cl);
    logic sp;
    sp = s;
    c1 = 1'b1;
    @(negedge clk);
    c1 = 1'b0;
    c2 = 1'b1;
    c3 = ~sp;
    @(negedge clk);
    c2 = 1'b0;
    c3 = 1'b0;
    c4 = 1'b1;
    cl = count7;
    if (last && s) c2 = 1'b1;
    @(negedge clk);
    c4 = 1'b0;
    c2 = 1'b0;
  endtask

  task automatic readout(output logic [W-1:0] r,
                         output logic [W-1:0] q,
                         output logic [5:0] fl);
    c5 = 1'b1;
    @(negedge clk);
    c5 = 1'b0;
    r = outbus;
    fl[0] = out_sel;
    fl[1] = out_valid;
    c6 = 1'b1;
    @(negedge clk);
    c6 = 1'b0;
    q = outbus;
    fl[2] = out_sel;
    fl[3] = out_valid;
    @(negedge clk);
    fl[4] = out_valid;
    fl[5] = div0;
  endtask

  task automatic test_div(input logic [W-1:0] a,
                          input logic [W-1:0] b);
    logic [W-1:0] r, q, er, eq;
    logic [5:0] fl, efl;
    bit cl, c7ok;
    er = W'(int'(a) % int'(b));
    eq = W'(int'(a) / int'(b));
    efl = {1'b0, 1'b0, 1'b1, OUT_SEL_QUO,
           1'b1, OUT_SEL_REM};
    c7ok = 1'b1;
    start(a, b);
    for (int i = 0; i < W; i++) begin
      iter(i == W - 1, cl);
      if (cl != (i == W - 1)) c7ok = 1'b0;
    end
    readout(r, q, fl);
    vectors++;
    if (r !== er) begin
      miscompares++;
      $display("FAIL rem %0d/%0d got %0d want %0d",
               a, b, r, er);
    end
    vectors++;
    if (q !== eq) begin
      miscompares++;
      $display("FAIL quo %0d/%0d got %0d want %0d",
               a, b, q, eq);
    end
    vectors++;
    if (fl !== efl) begin
      miscompares++;
      $display("FAIL flags %0d/%0d got %b want %b",
               a, b, fl, efl);
    end
    vectors++;
    if (!c7ok) begin
      miscompares++;
      $display("FAIL count7 %0d/%0d got bad want W-th",
               a, b);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({s, count7, outbus, out_valid, out_sel, div0}
        !== '0) begin
      miscompares++;
      $display("FAIL reset_state got %b want 0",
               {s, count7, outbus, out_valid,
                out_sel, div0});
    end
  endtask

  task automatic test_directed;
    test_div(8'd100, 8'd7);
    test_div(8'd200, 8'd13);
    test_div(8'd255, 8'd1);
    test_div(8'd5, 8'd9);
  endtask

  task automatic test_random;
    logic [W-1:0] a, b;
    for (int n = 0; n < 20; n++) begin
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(1, 255));
      if (n < 5) a[W-1] = 1'b1;
      test_div(a, b);
    end
  endtask

  task automatic test_mid_reset;
    logic [W-1:0] r, q;
    logic [5:0] fl;
    bit cl;
    start(8'd100, 8'd7);
    for (int i = 0; i < 4; i++) iter(1'b0, cl);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({s, count7, outbus, out_valid, out_sel}
        !== '0) begin
      miscompares++;
      $display("FAIL mid_reset got %b want 0",
               {s, count7, outbus, out_valid,
                out_sel});
    end
    readout(r, q, fl);
    vectors++;
    if ({r, q} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_aq got %h want 0",
               {r, q});
    end
    test_div(8'd100, 8'd7);
  endtask

  task automatic test_strobes;
    int ma, mq;
    logic [W-1:0] r;
    ma = 0;
    mq = 8'h80;
    start(8'h80, 8'd5);
    c3 = 1'b1;
    @(negedge clk);
    c3 = 1'b0;
    c5 = 1'b1;
    @(negedge clk);
    c5 = 1'b0;
    r = outbus;
    vectors++;
    if (r !== W'(ma % 256)) begin
      miscompares++;
      $display("FAIL c3_alone got %0d want %0d",
               r, ma % 256);
    end
    c1 = 1'b1;
    c2 = 1'b1;
    ma = (ma * 2 + mq / 128) % 512;
    mq = (mq * 2) % 256;
    @(negedge clk);
    c1 = 1'b0;
    c2 = 1'b0;
    c5 = 1'b1;
    @(negedge clk);
    c5 = 1'b0;
    r = outbus;
    vectors++;
    if (r !== W'(ma % 256)) begin
      miscompares++;
      $display("FAIL c1_c2 got %0d want %0d",
               r, ma % 256);
    end
    c2 = 1'b1;
    c3 = 1'b1;
    ma = (ma - 5 + 512) % 512;
    @(negedge clk);
    c2 = 1'b0;
    c3 = 1'b0;
    c5 = 1'b1;
    @(negedge clk);
    c5 = 1'b0;
    vectors++;
    if ({s, outbus} !== 9'(ma)) begin
      miscompares++;
      $display("FAIL sub_wrap got %h want %h",
               {s, outbus}, 9'(ma));
    end
    c6 = 1'b1;
    @(negedge clk);
    c6 = 1'b0;
    vectors++;
    if (outbus !== W'(mq)) begin
      miscompares++;
      $display("FAIL q_shift got %h want %h",
               outbus, W'(mq));
    end
  endtask

  task automatic test_both_out;
    start(8'h5A, 8'd3);
    c5 = 1'b1;
    c6 = 1'b1;
    @(negedge clk);
    c5 = 1'b0;
    c6 = 1'b0;
    vectors++;
    if ({outbus, out_sel, out_valid}
        !== {8'h5A, OUT_SEL_QUO, 1'b1}) begin
      miscompares++;
      $display("FAIL c5_c6 got %h want %h",
               {outbus, out_sel, out_valid},
               {8'h5A, OUT_SEL_QUO, 1'b1});
    end
    @(negedge clk);
    vectors++;
    if ({outbus, out_valid} !== {8'h5A, 1'b0}) begin
      miscompares++;
      $display("FAIL hold got %h want %h",
               {outbus, out_valid}, {8'h5A, 1'b0});
    end
  endtask

  task automatic test_div0;
    logic [W-1:0] r, q;
    logic [5:0] fl;
    logic e0;
    bit cl;
`ifdef DIVDP_DIV0_DETECT_EN
    e0 = 1'b1;
`else
    e0 = 1'b0;
`endif
    start(8'd37, 8'd0);
    vectors++;
    if (div0 !== e0) begin
      miscompares++;
      $display("FAIL div0_set got %b want %b",
               div0, e0);
    end
    for (int i = 0; i < W; i++) iter(i == W - 1, cl);
    readout(r, q, fl);
    vectors++;
    if (fl[5] !== e0) begin
      miscompares++;
      $display("FAIL div0_sticky got %b want %b",
               fl[5], e0);
    end
`ifdef DIVDP_DIV0_DETECT_EN
    vectors++;
    if ({r, q} !== {8'd37, 8'hFF}) begin
      miscompares++;
      $display("FAIL div0_out got %h want %h",
               {r, q}, {8'd37, 8'hFF});
    end
`endif
    test_div(8'd100, 8'd7);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_mid_reset();
    test_strobes();
    test_both_out();
    test_div0();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
